// File: rtl/instr_fetch_unit_pkg.sv
// Shared types for the instruction fetch unit: fetch FSM states, the NOP encoding
// and the opcode map used by the control FSM.
package instr_fetch_unit_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } fetch_state_t;

    typedef enum logic [6:0] {
        RType        = 7'b0110011,
        IType_logic  = 7'b0010011,
        IType_load   = 7'b0000011,
        IType_jalr   = 7'b1100111,
        IType_system = 7'b1110011,
        SType        = 7'b0100011,
        BType        = 7'b1100011,
        UType_lui    = 7'b0110111,
        UType_auipc  = 7'b0010111,
        JType        = 7'b1101111
    } opcode_t;

    localparam logic [31:0] INSTR_NOP = 32'h0000_0013;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Instruction memory request/response bus: valid/ready request channel plus a
// single-beat read data return.
interface instr_fetch_unit_if #(
    parameter int XLEN = 32
);
    logic            req;
    logic [XLEN-1:0] addr;
    logic            gnt;
    logic            rvalid;
    logic [31:0]     rdata;

    modport master (output req, addr, input gnt, rvalid, rdata);
    modport slave  (input req, addr, output gnt, rvalid, rdata);

endinterface

// File: rtl/instr_fetch_unit.sv
// Multicycle fetch stage: owns PC/IR, fetches one word per fetch_req over imem.
// Optional macro FETCH_MISALIGN_CHECK_EN turns unaligned fetches into a misaligned pulse.
module instr_fetch_unit
    import instr_fetch_unit_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       fetch_req,
    input  logic                       pc_update,
    input  logic [XLEN-1:0]            pc_next,
    output logic [XLEN-1:0]            pc,
    output logic [XLEN-1:0]            old_pc,
    instr_fetch_unit_if.master         imem,
    output logic [31:0]                instr,
    output opcode_t                    opcode,
    output logic [4:0]                 rd,
    output logic [4:0]                 rs1,
    output logic [4:0]                 rs2,
    output logic [2:0]                 funct3,
    output logic [6:0]                 funct7,
    output logic                       instr_valid,
    output logic                       fetch_busy,
    output logic                       misaligned
);

    fetch_state_t    state, state_next;
    logic            start, accept, capture, fault;
    logic [XLEN-1:0] issue_pc;
    logic [XLEN-1:0] addr_q;

    // A fetch request seen while idle; it is either issued or rejected as a fault.
    assign start = (state == IDLE) & fetch_req;

`ifdef FETCH_MISALIGN_CHECK_EN
    assign fault = start & (pc[1:0] != 2'b00);

    always_ff @(posedge clk) begin
        if (reset) misaligned <= 1'b0;
        else       misaligned <= fault;
    end
`else
    assign fault      = 1'b0;
    assign misaligned = 1'b0;
`endif

    // NOTE: clocked state uses non-blocking assignments so every register samples
    // pre-edge values regardless of block ordering.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can
        // leave one unassigned and infer a latch.
        state_next = state;
        accept     = 1'b0;
        capture    = 1'b0;
        unique case (state)
            IDLE: begin
                if (start && !fault) begin
                    accept     = 1'b1;
                    state_next = ADDR;
                end
            end
            ADDR: begin
                if (imem.gnt) state_next = DATA;
            end
            DATA: begin
                if (imem.rvalid) begin
                    capture    = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // PC follows pc_update independently; the in-flight request keeps addr_q/issue_pc.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc          <= RESET_PC;
            old_pc      <= RESET_PC;
            issue_pc    <= RESET_PC;
            addr_q      <= RESET_PC;
            instr       <= INSTR_NOP;
            instr_valid <= 1'b0;
        end else begin
            if (pc_update) pc <= pc_next;
            if (start) instr_valid <= 1'b0;
            if (accept) begin
                addr_q   <= {pc[XLEN-1:2], 2'b00};
                issue_pc <= pc;
            end
            if (capture) begin
                instr       <= imem.rdata;
                old_pc      <= issue_pc;
                instr_valid <= 1'b1;
            end
        end
    end

    assign imem.req   = (state == ADDR);
    assign imem.addr  = addr_q;
    assign fetch_busy = (state != IDLE) | start;

    assign opcode = opcode_t'(instr[6:0]);
    assign rd     = instr[11:7];
    assign funct3 = instr[14:12];
    assign rs1    = instr[19:15];
    assign rs2    = instr[24:20];
    assign funct7 = instr[31:25];

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Multicycle instruction fetch stage feeding the control FSM and datapath. It owns the PC and instruction registers, issues read requests to instruction memory over a valid/ready handshake, and captures the returned word. It presents the decoded `opcode` and register fields downstream, and asserts a stall while a fetch is in flight.

## Interface
Parameters:
- `XLEN`, 32: PC and address width.
- `RESET_PC`, 32'h0000_0000: PC value loaded on reset.

Ports:
- `clk`  in  1  clock, all state updates on rising edge.
- `reset`  in  1  reset, synchronous, active-high.
- `fetch_req`  in  1  start a fetch at the current PC; the control FSM raises it in its FETCH state.
- `pc_update`  in  1  load `pc_next` into PC this edge.
- `pc_next`  in  XLEN  next PC value.
- `pc`  out  XLEN  current PC.
- `old_pc`  out  XLEN  address of the instruction currently held in IR.
- `imem_req`  out  1  request valid.
- `imem_addr`  out  XLEN  word address of the request; held stable while `imem_req` is high and `imem_gnt` is low.
- `imem_gnt`  in  1  request accepted.
- `imem_rvalid`  in  1  read data valid.
- `imem_rdata`  in  32  read data.
- `instr`  out  32  instruction register.
- `opcode`  out  `opcode_t`  `instr[6:0]`.
- `rd`, `rs1`, `rs2`  out  5 each  `instr[11:7]`, `instr[19:15]`, `instr[24:20]`.
- `funct3`  out  3  `instr[14:12]`.
- `funct7`  out  7  `instr[31:25]`.
- `instr_valid`  out  1  IR holds a completed fetch.
- `fetch_busy`  out  1  stall; the fetch has not completed.
- `misaligned`  out  1  fetch address fault pulse.

## Operation
- States: IDLE, ADDR, DATA.
- IDLE:
  - On `fetch_req`, latch `imem_addr <= {pc[XLEN-1:2],2'b00}` and the issue PC, clear `instr_valid`, then go to ADDR.
  - `imem_rvalid` is ignored in IDLE.
- ADDR:
  - `imem_req=1`.
  - On `imem_gnt`, go to DATA.
  - `imem_addr` does not change in this state.
- DATA:
  - `imem_req=0`.
  - On `imem_rvalid`, set `instr <= imem_rdata`, `old_pc <=` issue PC, `instr_valid <= 1`, then go to IDLE.
- `fetch_busy = (state != IDLE) | (state==IDLE & fetch_req)`.
- `fetch_req` while in ADDR or DATA is ignored, with no queuing.
- `pc_update` is honoured in every state and does not affect an in-flight request, which uses the latched address.
  - Simultaneous `pc_update` and `fetch_req` in IDLE: the fetch uses the old PC, and PC takes `pc_next`.
- `instr_valid` stays high until the next accepted `fetch_req`.
- `instr` holds its value between fetches.
- Decoded fields are combinational slices of `instr`.
- Reset values:
  - state IDLE, `pc=RESET_PC`, `old_pc=RESET_PC`.
  - `instr=32'h0000_0013` (NOP), `instr_valid=0`, `imem_req=0`, `imem_addr=RESET_PC`, `misaligned=0`.
- Reset mid-fetch aborts immediately. Memory is reset by the same `reset`, so no stale response is returned.

## Timing
- `fetch_req` sampled at edge N; `imem_req` high from cycle N+1.
- Minimum `imem_gnt` latency is 0 cycles, so the grant can come in cycle N+1.
- `imem_rvalid` arrives no earlier than the cycle after the grant.
- `instr`/`instr_valid` are visible the cycle after `imem_rvalid`.
- With a zero-wait memory, the best case is 3 cycles from `fetch_req` to `instr_valid`.
- Back-to-back: a new `fetch_req` is accepted in the cycle `instr_valid` first rises.

## Configuration
- `FETCH_MISALIGN_CHECK_EN` defined:
  - When `fetch_req` is accepted with `pc[1:0]!=0`, no bus request is issued.
  - `misaligned` pulses for 1 cycle, `instr_valid` stays 0, the state stays IDLE, and `fetch_busy` drops the next cycle.
- Undefined:
  - `misaligned` is tied 0.
  - Low PC bits are silently dropped from `imem_addr`.

## Structure
- Shared types package:
  - `fetch_state_t` enum.
  - `INSTR_NOP = 32'h0000_0013`.
  - Reuse of the existing `opcode_t`.
- Single module. Field slicing is inline; no sub-module is warranted.

## Test plan
- Reset, then `fetch_req`, with memory granting immediately and returning 0x00500093 next cycle: `instr=0x00500093`, `opcode=IType_logic`, `rd=1`, `instr_valid` high at cycle 3, `old_pc=0`.
- `imem_gnt` delayed 4 cycles: `imem_req` and `imem_addr` stable throughout; `fetch_busy` high until capture.
- `pc_update` with `pc_next=0x40` during DATA: captured `old_pc=0x0`, `pc=0x40`; the next fetch uses address 0x40.
- `fetch_req` pulsed again during ADDR: exactly one bus request; no second capture.
- `reset` asserted in DATA: next cycle `instr=0x00000013`, `instr_valid=0`, `pc=RESET_PC`, `imem_req=0`.
- With `FETCH_MISALIGN_CHECK_EN`, `pc=0x2` and `fetch_req`: `misaligned` is a 1-cycle pulse and `imem_req` never rises. Without the macro: `imem_addr=0x0` and a normal fetch.
